// File: rtl/fir_out_buf.sv
// Decimates the FIR output stream by DECIM and buffers kept samples in a FWFT FIFO with a registered head.
// 1-cycle latency from en_in to dout; no input backpressure, so kept samples arriving while full are dropped and flagged in ovf.
module fir_out_buf #(
    parameter int WIDTH = 16,
    parameter int DECIM = 4,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         sig_in,
    input  logic                     en_in,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    input  logic                     clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(DECIM - 1);
    localparam logic [AW:0]   FULL    = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    phase;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [AW:0]      level_rem;
    logic [AW:0]      level_nxt;
    logic             keep;
    logic             pop;
    logic             push;
    logic             drop;

    always_comb begin
        keep       = en_in && (phase == '0);
        pop        = dout_valid && dout_ready;
        push       = keep && ((level != FULL) || pop);
        drop       = keep && !push;
        level_rem  = level - (AW + 1)'(pop);
        level_nxt  = level_rem + (AW + 1)'(push);
        rd_ptr_nxt = rd_ptr + AW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sig_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            if (en_in) begin
                phase <= (phase == PH_LAST) ? '0 : phase + PW'(1);
            end
            wr_ptr     <= wr_ptr + AW'(push);
            rd_ptr     <= rd_ptr_nxt;
            level      <= level_nxt;
            dout_valid <= (level_nxt != '0);
            // Head register: bypass the input when it becomes the only entry, otherwise
            // preload the next stored entry on a pop; it holds its value otherwise.
            if (push && (level_rem == '0)) begin
                dout <= sig_in;
            end else if (pop && (level_rem != '0)) begin
                dout <= mem[rd_ptr_nxt];
            end
            if (drop) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_out_buf.sv
// Scoreboard bench: one DECIM=4 and one DECIM=1 instance, directed vectors, monitor pops expected queues.
module tb_fir_out_buf;

    typedef struct {
        int d;
        int c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    int          cyc = 0;
    int          errs = 0;
    int          checks = 0;
    exp_t        q4[$];
    exp_t        q1[$];

    logic [15:0] s4 = '0, s1 = '0;
    logic        e4 = 1'b0, e1 = 1'b0;
    logic        r4 = 1'b0, r1 = 1'b0;
    logic        clr4 = 1'b0, clr1 = 1'b0;
    logic [15:0] dout4, dout1;
    logic        v4, v1;
    logic [3:0]  level4, level1;
    logic        ovf4, ovf1;

    fir_out_buf #(.WIDTH(16), .DECIM(4), .DEPTH(8)) u_d4 (
        .clk(clk), .rst_n(rst_n), .sig_in(s4), .en_in(e4),
        .dout(dout4), .dout_valid(v4), .dout_ready(r4),
        .level(level4), .ovf(ovf4), .clr_ovf(clr4)
    );

    fir_out_buf #(.WIDTH(16), .DECIM(1), .DEPTH(8)) u_d1 (
        .clk(clk), .rst_n(rst_n), .sig_in(s1), .en_in(e1),
        .dout(dout1), .dout_valid(v1), .dout_ready(r1),
        .level(level1), .ovf(ovf1), .clr_ovf(clr1)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp4(input int d, input int c);
        exp_t e;
        e.d = d; e.c = c;
        q4.push_back(e);
    endtask

    task automatic exp1(input int d, input int c);
        exp_t e;
        e.d = d; e.c = c;
        q1.push_back(e);
    endtask

    task automatic drain(input string name);
        int left;
        left = 1;
        for (int k = 0; k < 40 && left != 0; k++) begin
            step();
            left = q4.size() + q1.size() + int'(level4) + int'(level1);
        end
        chk(name, left, 0);
    endtask

    // Monitor: every handshake on either instance must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && v4 && r4) begin
            if (q4.size() == 0) begin
                chk("d4_unexpected_out", int'(dout4), -1);
            end else begin
                e = q4.pop_front();
                chk("d4_dout", int'(dout4), e.d);
                if (e.c >= 0) chk("d4_latency", cyc, e.c);
            end
        end
        if (rst_n && v1 && r1) begin
            if (q1.size() == 0) begin
                chk("d1_unexpected_out", int'(dout1), -1);
            end else begin
                e = q1.pop_front();
                chk("d1_dout", int'(dout1), e.d);
                if (e.c >= 0) chk("d1_latency", cyc, e.c);
            end
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        #2;
        chk("rst_dout", int'(dout4), 0);
        chk("rst_valid", int'(v4), 0);
        chk("rst_level", int'(level4), 0);
        chk("rst_ovf", int'(ovf4), 0);
        chk("rst_level_d1", int'(level1), 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // T1: decimation by 4, outputs 1,5,9 one cycle after input
        r4 = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            s4 = 16'(i); e4 = 1'b1;
            if ((i - 1) % 4 == 0) exp4(i, cyc + 1);
            step();
        end
        e4 = 1'b0;
        step();
        chk("t1_ovf", int'(ovf4), 0);
        chk("t1_level", int'(level4), 0);

        // T2: en_in every 3rd cycle, values 10..17, expect 10,14
        for (int i = 0; i < 8; i++) begin
            s4 = 16'(10 + i); e4 = 1'b1;
            if (i % 4 == 0) exp4(10 + i, cyc + 1);
            step();
            e4 = 1'b0;
            step();
            step();
        end
        drain("t2_drain");

        // T3: DECIM=1 fill and overflow
        r1 = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (i == 9) chk("t3_ovf_before", int'(ovf1), 0);
            if (i == 10) chk("t3_ovf_set", int'(ovf1), 1);
            s1 = 16'(i); e1 = 1'b1;
            if (i <= 8) exp1(i, -1);
            step();
        end
        e1 = 1'b0;
        chk("t3_level_full", int'(level1), 8);
        chk("t3_ovf_sticky", int'(ovf1), 1);
        chk("t3_head", int'(dout1), 1);
        r1 = 1'b1;
        drain("t3_drain");
        chk("t3_valid_low", int'(v1), 0);
        chk("t3_ovf_held", int'(ovf1), 1);
        clr1 = 1'b1;
        step();
        clr1 = 1'b0;
        chk("t3_ovf_clr", int'(ovf1), 0);

        // T4: full with simultaneous push and pop
        r1 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            s1 = 16'(i); e1 = 1'b1; exp1(i, -1);
            step();
        end
        e1 = 1'b0;
        chk("t4_full", int'(level1), 8);
        s1 = 16'd9; e1 = 1'b1; r1 = 1'b1; exp1(9, -1);
        step();
        e1 = 1'b0; r1 = 1'b0;
        chk("t4_level", int'(level1), 8);
        chk("t4_ovf", int'(ovf1), 0);
        chk("t4_head", int'(dout1), 2);
        r1 = 1'b1;
        drain("t4_drain");

        // T5: drop with clr_ovf asserted -> set wins; then clear
        r1 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            s1 = 16'(20 + i); e1 = 1'b1; exp1(20 + i, -1);
            step();
        end
        s1 = 16'd99; e1 = 1'b1; clr1 = 1'b1;
        step();
        e1 = 1'b0;
        chk("t5_set_wins", int'(ovf1), 1);
        chk("t5_level", int'(level1), 8);
        step();
        clr1 = 1'b0;
        chk("t5_clear", int'(ovf1), 0);
        r1 = 1'b1;
        drain("t5_drain");

        // T6: async reset with level=5, phase=2 on the DECIM=4 instance
        r4 = 1'b0;
        for (int i = 0; i < 18; i++) begin
            s4 = 16'(100 + i); e4 = 1'b1;
            step();
        end
        e4 = 1'b0;
        chk("t6_level_pre", int'(level4), 5);
        chk("t6_head_pre", int'(dout4), 100);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", int'(v4), 0);
        chk("t6_rst_level", int'(level4), 0);
        chk("t6_rst_ovf", int'(ovf4), 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        r4 = 1'b1; s4 = 16'd42; e4 = 1'b1; exp4(42, cyc + 1);
        step();
        e4 = 1'b0;
        chk("t6_first_kept", int'(dout4), 42);
        drain("t6_drain");

        chk("final_queues_empty", q4.size() + q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
